// File: rtl/sram_port_arbiter.sv
// Three-port arbiter and strobe sequencer for a single 16-bit asynchronous SRAM.
// Define ARB_ROUND_ROBIN_EN for rotating priority; default is fixed priority 0 > 1 > 2.
module sram_port_arbiter #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [15:0]       wdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              ack1,
  input  logic              req2,
  input  logic [ADDR_W-1:0] addr2,
  output logic              ack2,
  output logic [15:0]       rdata,
  output logic              busy,
  inout  wire  [15:0]       memDataBus,
  output logic [ADDR_W-1:0] memAddrBus,
  output logic              memEnable,
  output logic              memRead,
  output logic              memWrite
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [1:0]          port_q, port_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [15:0]         wdata_q, wdata_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [15:0]         rdata_q, rdata_d;

  logic [2:0]          req_vec;
  logic                grant_valid;
  logic [1:0]          grant_id;
  logic                drive_bus;

  assign req_vec = {req2, req1, req0};

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0] last_q, last_d;

  // Search starts at the port after the last winner, wrapping modulo 3.
  always_comb begin
    int cand;
    grant_valid = 1'b0;
    grant_id    = 2'd0;
    for (int i = 0; i < 3; i++) begin
      cand = int'(last_q) + 1 + i;
      if (cand >= 3) cand = cand - 3;
      if (!grant_valid && req_vec[cand]) begin
        grant_valid = 1'b1;
        grant_id    = cand[1:0];
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (state_q == S_IDLE && grant_valid) last_d = grant_id;
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= 2'd2;
    else     last_q <= last_d;
  end
`else
  always_comb begin
    grant_valid = |req_vec;
    if (req_vec[0])      grant_id = 2'd0;
    else if (req_vec[1]) grant_id = 2'd1;
    else                 grant_id = 2'd2;
  end
`endif

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_valid) begin
          port_d  = grant_id;
          cnt_d   = 4'(WAIT_CYCLES - 1);
          state_d = S_ACCESS;
          unique case (grant_id)
            2'd0: begin
              addr_d  = addr0;
              we_d    = we0;
              wdata_d = wdata0;
            end
            2'd1: begin
              addr_d  = addr1;
              we_d    = 1'b0;
              wdata_d = 16'h0000;
            end
            default: begin
              addr_d  = addr2;
              we_d    = 1'b0;
              wdata_d = 16'h0000;
            end
          endcase
        end
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (!we_q) rdata_d = memDataBus;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      port_q  <= 2'd0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= 16'h0000;
      cnt_q   <= 4'd0;
      rdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Write data stays on the pins through DONE to give the SRAM hold time after WE rises.
  always_comb begin
    memEnable = 1'b1;
    memRead   = 1'b1;
    memWrite  = 1'b1;
    drive_bus = 1'b0;
    unique case (state_q)
      S_ACCESS: begin
        memEnable = 1'b0;
        if (we_q) begin
          memWrite  = 1'b0;
          drive_bus = 1'b1;
        end else begin
          memRead = 1'b0;
        end
      end
      S_DONE:  drive_bus = we_q;
      default: ;
    endcase
  end

  assign memDataBus = drive_bus ? wdata_q : 16'hzzzz;
  assign memAddrBus = addr_q;
  assign busy       = (state_q != S_IDLE);
  assign rdata      = rdata_q;
  assign ack0       = (state_q == S_DONE) && (port_q == 2'd0);
  assign ack1       = (state_q == S_DONE) && (port_q == 2'd1);
  assign ack2       = (state_q == S_DONE) && (port_q == 2'd2);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: directed accesses against a behavioural SRAM.
module tb_sram_port_arbiter;

  localparam int WAIT = 2;
  localparam int AW   = 18;
  localparam int LAT  = WAIT + 2;  // negedges from request drive to ack, idle arbiter

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, req2 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0, addr2 = '0;
  logic [15:0]   wdata0 = '0;
  logic          ack0, ack1, ack2, busy;
  logic [15:0]   rdata;
  wire  [15:0]   memDataBus;
  logic [AW-1:0] memAddrBus;
  logic          memEnable, memRead, memWrite;

  sram_port_arbiter #(.WAIT_CYCLES(WAIT), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .addr1(addr1), .ack1(ack1),
    .req2(req2), .addr2(addr2), .ack2(ack2),
    .rdata(rdata), .busy(busy),
    .memDataBus(memDataBus), .memAddrBus(memAddrBus),
    .memEnable(memEnable), .memRead(memRead), .memWrite(memWrite)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: drives the pins only while CE and OE are both low.
  logic [15:0] sram [0:(1<<AW)-1];
  assign memDataBus = (!memEnable && !memRead) ? sram[memAddrBus] : 16'hzzzz;

  initial begin
    sram[18'h00123] = 16'hBEEF;
    sram[18'h00010] = 16'h1111;
    sram[18'h00011] = 16'h2222;
    sram[18'h00012] = 16'h3333;
    sram[18'h00200] = 16'hAAAA;
    sram[18'h00201] = 16'hBBBB;
    sram[18'h00202] = 16'hCCCC;
    forever begin
      @(posedge clk);
      if (!memEnable && !memWrite) sram[memAddrBus] = memDataBus;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0]  port;
    logic        we;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] exp_rd = 16'h0000;

  task automatic push(input logic [1:0] p, input bit we, input logic [15:0] wd, input logic [15:0] rd);
    exp_t e;
    e.port  = p;
    e.we    = we;
    e.wdata = wd;
    if (!we) exp_rd = rd;
    e.rdata = exp_rd;
    sb_q.push_back(e);
  endtask

  // Monitor: every ack pops one expectation and checks port, rdata and write hold data.
  always @(negedge clk) begin : monitor
    int   p;
    exp_t e;
    if (!rst && (ack0 || ack1 || ack2)) begin
      p = ack0 ? 0 : (ack1 ? 1 : 2);
      check($countones({ack0, ack1, ack2}) == 1, "ack_onehot", {ack2, ack1, ack0}, 32'h0);
      if (sb_q.size() == 0) begin
        check(1'b0, "unexpected_ack", p, 32'hFFFF);
      end else begin
        e = sb_q.pop_front();
        check(p == int'(e.port), "ack_port", p, e.port);
        check(rdata == e.rdata, "rdata", rdata, e.rdata);
        if (e.we) check(memDataBus == e.wdata, "write_hold", memDataBus, e.wdata);
      end
    end
  end

  // Strobe monitor: each CE-low run lasts WAIT cycles, and OE/WE are never low together.
  int strobe_run = 0;
  always @(negedge clk) begin
    if (rst) begin
      strobe_run = 0;
    end else if (!memEnable) begin
      strobe_run++;
      check(memRead || memWrite, "oe_we_both_low", {memRead, memWrite}, 32'h3);
    end else if (strobe_run != 0) begin
      check(strobe_run == WAIT, "strobe_len", strobe_run, WAIT);
      strobe_run = 0;
    end
  end

  function automatic bit ack_of(input int p);
    return (p == 0) ? ack0 : ((p == 1) ? ack1 : ack2);
  endfunction

  task automatic drive(input int p, input bit r, input bit we, input logic [AW-1:0] a, input logic [15:0] wd);
    case (p)
      0: begin req0 = r; we0 = we; addr0 = a; wdata0 = wd; end
      1: begin req1 = r; addr1 = a; end
      default: begin req2 = r; addr2 = a; end
    endcase
  endtask

  // Issue one request, wait (bounded) for its ack, check latency, drop req after the ack cycle.
  task automatic run_port(input int p, input bit we, input logic [AW-1:0] a, input logic [15:0] wd,
                          input int exp_lat);
    int n;
    bit got;
    @(posedge clk); #1;
    drive(p, 1'b1, we, a, wd);
    n   = 0;
    got = 1'b0;
    while (!got && n < 60) begin
      @(negedge clk);
      n++;
      got = ack_of(p);
    end
    check(got && n == exp_lat, "latency", n, exp_lat);
    @(posedge clk); #1;
    drive(p, 1'b0, 1'b0, a, wd);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_rd = 16'h0000;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int  n, k;
    bit  got;
    logic [AW-1:0] b2b_addr [3];
    logic [15:0]   b2b_data [3];
    b2b_addr = '{18'h00010, 18'h00011, 18'h00012};
    b2b_data = '{16'h1111, 16'h2222, 16'h3333};

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check(!busy, "rst_busy", busy, 0);
    check({memEnable, memRead, memWrite} == 3'b111, "rst_strobes", {memEnable, memRead, memWrite}, 3'b111);
    check(memAddrBus == '0, "rst_addr", memAddrBus, 0);
    check({ack0, ack1, ack2} == 3'b000, "rst_acks", {ack0, ack1, ack2}, 0);
    check(rdata == 16'h0000, "rst_rdata", rdata, 0);

    // Single read on the fetch port
    push(2'd1, 1'b0, 16'h0, 16'hBEEF);
    run_port(1, 1'b0, 18'h00123, 16'h0, LAT);

    // Single write at the top address, then read it back from the graphics port
    push(2'd0, 1'b1, 16'hA55A, 16'h0);
    run_port(0, 1'b1, 18'h3FFFF, 16'hA55A, LAT);
    push(2'd2, 1'b0, 16'h0, 16'hA55A);
    run_port(2, 1'b0, 18'h3FFFF, 16'h0, LAT);

    // Contention: all three rise together after reset, acks 4 cycles apart in order 0,1,2
    do_reset();
    push(2'd0, 1'b0, 16'h0, 16'hAAAA);
    push(2'd1, 1'b0, 16'h0, 16'hBBBB);
    push(2'd2, 1'b0, 16'h0, 16'hCCCC);
    fork
      run_port(0, 1'b0, 18'h00200, 16'h0, LAT);
      run_port(1, 1'b0, 18'h00201, 16'h0, LAT + WAIT + 2);
      run_port(2, 1'b0, 18'h00202, 16'h0, LAT + 2 * (WAIT + 2));
    join

    // Reset during the second ACCESS cycle of a write
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b1, 18'h00055, 16'h1234);
    @(posedge clk);                 // grant edge
    @(posedge clk); #1;             // now in second ACCESS cycle
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 18'h00055, 16'h1234);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_rd = 16'h0000;
    @(negedge clk);
    check({memEnable, memRead, memWrite} == 3'b111, "midrst_strobes", {memEnable, memRead, memWrite}, 3'b111);
    check(!busy, "midrst_busy", busy, 0);
    check({ack0, ack1, ack2} == 3'b000, "midrst_acks", {ack0, ack1, ack2}, 0);
    check(rdata == 16'h0000, "midrst_rdata", rdata, 0);
    push(2'd1, 1'b0, 16'h0, 16'hBEEF);
    run_port(1, 1'b0, 18'h00123, 16'h0, LAT);

    // Back-to-back reads on the data port with req held high
    for (int i = 0; i < 3; i++) push(2'd0, 1'b0, 16'h0, b2b_data[i]);
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, b2b_addr[0], 16'h0);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      got = 1'b0;
      while (!got && n < 60) begin
        @(negedge clk);
        n++;
        got = ack0;
      end
      check(got && n == LAT, "b2b_period", n, LAT);
      @(posedge clk); #1;
      if (i < 2) drive(0, 1'b1, 1'b0, b2b_addr[i+1], 16'h0);
      else       drive(0, 1'b0, 1'b0, b2b_addr[i], 16'h0);
      @(negedge clk);
      check({memEnable, memRead, memWrite, busy} == 4'b1110, "b2b_idle_gap",
            {memEnable, memRead, memWrite, busy}, 4'b1110);
      n = 1;
    end

    // Early withdrawal: req2 dropped right after the grant edge
    push(2'd2, 1'b0, 16'h0, 16'hBBBB);
    @(posedge clk); #1;
    drive(2, 1'b1, 1'b0, 18'h00201, 16'h0);
    @(posedge clk); #1;
    drive(2, 1'b0, 1'b0, 18'h00201, 16'h0);
    n   = 0;
    got = 1'b0;
    while (!got && n < 60) begin
      @(negedge clk);
      n++;
      got = ack2;
    end
    check(got && n == WAIT + 1, "withdraw_ack", n, WAIT + 1);
    got = 1'b0;
    repeat (6) begin
      @(negedge clk);
      got = got | busy;
    end
    check(!got, "withdraw_no_reissue", got, 0);

    // Saturation: requests held continuously for four grants
    do_reset();
`ifdef ARB_ROUND_ROBIN_EN
    push(2'd0, 1'b0, 16'h0, 16'hAAAA);
    push(2'd1, 1'b0, 16'h0, 16'hBBBB);
    push(2'd2, 1'b0, 16'h0, 16'hCCCC);
    push(2'd0, 1'b0, 16'h0, 16'hAAAA);
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 18'h00200, 16'h0);
    drive(1, 1'b1, 1'b0, 18'h00201, 16'h0);
    drive(2, 1'b1, 1'b0, 18'h00202, 16'h0);
`else
    repeat (4) push(2'd0, 1'b0, 16'h0, 16'hAAAA);
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 18'h00200, 16'h0);
    drive(2, 1'b1, 1'b0, 18'h00202, 16'h0);
`endif
    k = 0;
    n = 0;
    while (k < 4 && n < 100) begin
      @(negedge clk);
      n++;
      if (ack0 || ack1 || ack2) k++;
    end
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 18'h00200, 16'h0);
    drive(1, 1'b0, 1'b0, 18'h00201, 16'h0);
    drive(2, 1'b0, 1'b0, 18'h00202, 16'h0);
    check(k == 4 && n == 4 * (WAIT + 2), "sat_grants", n, 4 * (WAIT + 2));

    repeat (8) @(negedge clk);
    check(sb_q.size() == 0, "sb_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Sequences the single external 16-bit SRAM (18-bit address, active-low strobes) and shares it among three requesters.
- Requesters: CPU data port (read/write), CPU instruction-fetch port (read-only), graphics/DMA read port.
- Sits between the CPU address-mapping logic and the board SRAM pins.
- Issues one access at a time through a fixed-length strobe sequence and returns read data with a per-port one-cycle ack.

Parameters:
- WAIT_CYCLES, 2, number of clk cycles the strobes stay asserted per access; legal range 1..15.
- ADDR_W, 18, SRAM address width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0  in  1  data-port request.
- we0  in  1  data-port write enable (1 = write).
- addr0  in  ADDR_W  data-port address.
- wdata0  in  16  data-port write data.
- ack0  out  1  data-port completion pulse.
- req1  in  1  fetch-port request (read only).
- addr1  in  ADDR_W  fetch-port address.
- ack1  out  1  fetch-port completion pulse.
- req2  in  1  graphics-port request (read only).
- addr2  in  ADDR_W  graphics-port address.
- ack2  out  1  graphics-port completion pulse.
- rdata  out  16  read data, valid in the cycle the granted ack is high; shared by all ports.
- busy  out  1  high in any state other than IDLE.
- memDataBus  inout  16  SRAM data pins.
- memAddrBus  out  ADDR_W  SRAM address pins.
- memEnable, memRead, memWrite  out  1 each  SRAM chip-enable, output-enable and write-enable; all active-low.

Behaviour:
- Reset state (rst=1 at a clock edge, effective the next cycle, including mid-access):
  - State goes to IDLE.
  - memEnable=memRead=memWrite=1; memDataBus high-Z; memAddrBus=0.
  - ack0..2=0; rdata=0; busy=0; wait counter=0.
  - The access in flight is abandoned with no ack.
- States: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - Strobes deasserted; bus high-Z.
  - If any req is high, pick a winner by priority (0 > 1 > 2).
  - Latch the winner's port id, address, we (forced 0 for ports 1/2) and wdata.
  - Load the counter with WAIT_CYCLES-1; go to ACCESS.
- ACCESS:
  - memAddrBus = latched address; memEnable=0.
  - Read: memRead=0, memWrite=1, bus high-Z.
  - Write: memWrite=0, memRead=1, bus driven with latched wdata.
  - Counter decrements each cycle. When the counter is 0: for a read, capture memDataBus into rdata; go to DONE.
- DONE:
  - memEnable, memRead and memWrite return to 1; address held.
  - For a write, the bus stays driven with wdata this one cycle as hold time.
  - The granted ack is 1 for exactly this cycle; go to IDLE.
- Latency: ack occurs WAIT_CYCLES+1 cycles after the IDLE cycle that sampled req.
- Throughput: back-to-back accesses are separated by one IDLE cycle. Period is WAIT_CYCLES+2 cycles.
- Handshake:
  - A requester holds req and its addr/we/wdata stable until it sees ack.
  - It may drop req in the ack cycle. If req is still high in the following IDLE cycle, that is a new request.
  - Port inputs are latched at grant, so later changes do not affect the access in flight.
  - If req is withdrawn before ack, the access still completes and ack still pulses.
- Simultaneous requests: exactly one grant per IDLE cycle. Losers wait with req held, with no timeout.
- At most one of ack0..2 is high in any cycle.
- rdata holds its value until the next read completes; writes do not change rdata.
- The bus is never driven while memRead=0; write data is never driven in IDLE.

Optional Feature:
- ARB_ROUND_ROBIN_EN defined:
  - Priority rotates; the port granted last gets the lowest priority at the next grant.
  - After reset the order is 0 > 1 > 2.
  - Example: after granting 1, the order is 2 > 0 > 1.
- Undefined: fixed priority 0 > 1 > 2. Port 2 can starve while ports 0/1 stay saturated.

Test Plan (WAIT_CYCLES=2):
- Single read: SRAM model returns 0xBEEF at 0x00123; req1=1, addr1=0x00123 -> memEnable/memRead low for 2 cycles; ack1 3 cycles after the req sample; rdata=0xBEEF; bus never driven.
- Single write: req0=1, we0=1, addr0=0x3FFFF, wdata0=0xA55A -> memWrite low for 2 cycles; bus=0xA55A through DONE; ack0; a later read of 0x3FFFF returns 0xA55A.
- Contention: req0, req1 and req2 rise in the same cycle and are held until their acks -> acks in order 0, 1, 2, spaced 4 cycles apart. With ARB_ROUND_ROBIN_EN and all three held continuously, grants rotate 0, 1, 2, 0.
- Reset mid-access: assert rst during the second ACCESS cycle of a write -> next cycle all strobes high, bus high-Z, no ack, busy=0; a following read completes normally.
- Back-to-back: req0 held high with new addresses after each ack -> grants every 4 cycles; exactly one IDLE cycle with all strobes high between accesses.
- Early withdrawal: req2 dropped the cycle after grant -> access completes; ack2 still pulses; no second access is started.
